// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets N valid/ready producers share
// the single write port of a fifo_synch. Grants last at most MAX_BURST words.
// The FIFO write enable and data come from one register stage.
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int DEPTH     = 64,
  parameter int CW        = 8,
  parameter int MAX_BURST = 4,
  localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  input  logic           fifo_buf_full,
  input  logic [CW-1:0]  fifo_counter,
  output logic           fifo_wr_en,
  output logic [W-1:0]   fifo_buf_in,
  output logic [IW-1:0]  grant_id,
  output logic           busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state;
  state_t         next_state;
  logic [IW-1:0]  owner;
  logic [IW-1:0]  rr_ptr;
  logic [7:0]     burst_cnt;
  logic           vld_p1;
  logic [W-1:0]   data_p1;
  logic           space;
  logic           sel_found;
  logic [IW-1:0]  sel_id;
  logic [W-1:0]   owner_data;
  logic           xfer;
  logic           burst_last;
  logic           burst_exit;

  // Room for one more word: occupancy plus the write already in flight must
  // stay below DEPTH. The sum is one bit wider so it cannot wrap. Reads are
  // not visible here, so the answer errs on the safe side.
  function automatic logic has_space(input logic full, input logic [CW-1:0] cnt,
                                     input logic wr_inflight);
    logic [CW:0] sum;
    sum = {1'b0, cnt} + {{CW{1'b0}}, wr_inflight};
    return !full && (sum < (CW+1)'(DEPTH));
  endfunction

  assign space      = has_space(fifo_buf_full, fifo_counter, vld_p1);
  assign owner_data = req_data[int'(owner)*W +: W];
  assign xfer       = (state == BURST) && req_valid[owner] && space;
  assign burst_last = xfer && (burst_cnt == 8'(MAX_BURST - 1));
  assign burst_exit = (state == BURST) && (burst_last || (!req_valid[owner] && space));

  // Pick the first valid requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_id    = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel_id    = IW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next state: grant from IDLE when someone is valid and the FIFO has room;
  // leave BURST on the last word or when the owner goes quiet with room.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sel_found && space) next_state = BURST;
      BURST:   if (burst_exit)         next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: only the owner sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    if (state == BURST) req_ready[owner] = space;
  end

  // ---- stage p1: registered FIFO write plus grant bookkeeping ----
  // Capture accepted words and track owner, burst length and priority pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1    <= 1'b0;
      data_p1   <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      vld_p1 <= xfer;
      if (xfer) begin
        data_p1   <= owner_data;
        burst_cnt <= burst_cnt + 8'd1;
      end
      if (state == IDLE && sel_found && space) begin
        owner     <= sel_id;
        burst_cnt <= '0;
      end
      if (burst_exit) rr_ptr <= (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
    end
  end

  assign fifo_wr_en  = vld_p1;
  assign fifo_buf_in = data_p1;
  assign grant_id    = owner;
  assign busy        = (state == BURST);

endmodule
